// File: rtl/kes_mem_arbiter.sv
// kes_mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single asynchronous-handshake SRAM. Round-robin between simultaneous
// requesters, one access in flight at a time, 3-state FSM (IDLE/BUSY/RESP).
// Optional build macro: KES_ARB_TIMEOUT_EN adds a BUSY watchdog that ends a
// stuck access with an error response after TIMEOUT clocks.
module kes_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_start,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state;
  logic [1:0] done_sync;
  logic       done_s;
  logic       last_d;   // 1 = D port was granted last, 0 = I port
  logic       grant_d;  // port owning the access in flight
  logic       pick_d;

`ifdef KES_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_expire;
  logic       i_err_r;
  logic       d_err_r;

  // The count held during a BUSY cycle is the number of BUSY cycles already
  // spent, so this cycle is the one where the count reaches TIMEOUT.
  assign wd_expire = (8'(wd_cnt + 8'd1) == 8'(TIMEOUT));
  assign i_err     = i_err_r;
  assign d_err     = d_err_r;
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif

  assign done_s = done_sync[1];
  assign busy   = (state != IDLE);

  // Arbitration: a lone requester always wins; with both requesting, the
  // port that was not served last wins.
  always_comb begin
    pick_d = d_req && (!i_req || !last_d);
  end

  // Two-flop synchronizer for the SRAM done line, which is not clock-related.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_sync <= 2'b00;
    end else begin
      done_sync <= {done_sync[0], mem_done};
    end
  end

  // Main FSM; every output it drives is a register so mem_* stay glitch free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_start <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      last_d    <= 1'b0;
      grant_d   <= 1'b0;
`ifdef KES_ARB_TIMEOUT_EN
      i_err_r   <= 1'b0;
      d_err_r   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // done_s still high means the SRAM has not released the last access.
          if (!done_s && (i_req || d_req)) begin
            grant_d   <= pick_d;
            mem_start <= 1'b1;
            if (pick_d) begin
              mem_write <= d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_write <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
`ifdef KES_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            state <= BUSY;
          end
        end

        BUSY: begin
`ifdef KES_ARB_TIMEOUT_EN
          wd_cnt <= 8'(wd_cnt + 8'd1);
`endif
          if (done_s) begin
            mem_start <= 1'b0;
            if (grant_d) begin
              if (!mem_write) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= RESP;
          end
`ifdef KES_ARB_TIMEOUT_EN
          else if (wd_expire) begin
            mem_start <= 1'b0;
            if (grant_d) begin
              d_rdata <= '0;
              d_err_r <= 1'b1;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_err_r <= 1'b1;
              i_ack   <= 1'b1;
            end
            state <= RESP;
          end
`endif
        end

        RESP: begin
          // The ack raised on entry lives exactly this one cycle.
          i_ack  <= 1'b0;
          d_ack  <= 1'b0;
`ifdef KES_ARB_TIMEOUT_EN
          i_err_r <= 1'b0;
          d_err_r <= 1'b0;
`endif
          last_d <= grant_d;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
